// File: rtl/cache_sa_wb.sv
// 2-way set-associative write-back/write-allocate cache with per-set LRU and saturating hit/miss counters.
// Hits complete in 0 wait cycles; a miss stalls the processor through optional write-back, fetch and one replay cycle.
module cache_sa_wb #(
  parameter int ADDR_W    = 30,
  parameter int DATA_W    = 32,
  parameter int NUM_SETS  = 4,
  parameter int BLK_WORDS = 4,
  parameter int CNT_W     = 16
) (
  input  logic                          clk,
  input  logic                          proc_reset,
  input  logic                          proc_read,
  input  logic                          proc_write,
  input  logic [ADDR_W-1:0]             proc_addr,
  input  logic [DATA_W-1:0]             proc_wdata,
  output logic [DATA_W-1:0]             proc_rdata,
  output logic                          proc_stall,
  output logic                          mem_read,
  output logic                          mem_write,
  output logic [ADDR_W-$clog2(BLK_WORDS)-1:0] mem_addr,
  output logic [DATA_W*BLK_WORDS-1:0]   mem_wdata,
  input  logic [DATA_W*BLK_WORDS-1:0]   mem_rdata,
  input  logic                          mem_ready,
  output logic [CNT_W-1:0]              hit_cnt,
  output logic [CNT_W-1:0]              miss_cnt
);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int OFF_W = $clog2(BLK_WORDS);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;

  typedef enum logic [1:0] {IDLE, WB, ALLOC} state_t;

  state_t                           state, state_nxt;
  logic [1:0]                       valid [NUM_SETS];
  logic [1:0]                       dirty [NUM_SETS];
  logic [NUM_SETS-1:0]              lru;
  logic [TAG_W-1:0]                 tag_q [2][NUM_SETS];
  logic [BLK_WORDS-1:0][DATA_W-1:0] blk_q [2][NUM_SETS];
  logic                             vic_way;
  logic                             retry;

  logic [OFF_W-1:0] off;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] req_tag;
  logic             hit0, hit1, hit, hit_way, vic_sel, lookup;

  assign off     = proc_addr[OFF_W-1:0];
  assign idx     = proc_addr[OFF_W+IDX_W-1:OFF_W];
  assign req_tag = proc_addr[ADDR_W-1:OFF_W+IDX_W];
  assign hit0    = valid[idx][0] && (tag_q[0][idx] == req_tag);
  assign hit1    = valid[idx][1] && (tag_q[1][idx] == req_tag);
  assign hit     = hit0 || hit1;
  assign hit_way = hit1;
  assign lookup  = (state == IDLE) && (proc_read || proc_write);
  // Fill empty ways first; only evict by LRU once the set is full.
  assign vic_sel = !valid[idx][0] ? 1'b0 : (!valid[idx][1] ? 1'b1 : lru[idx]);

  always_comb begin
    state_nxt  = state;
    proc_stall = 1'b0;
    proc_rdata = '0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = {req_tag, idx};
    mem_wdata  = blk_q[vic_way][idx];
    case (state)
      IDLE: begin
        if (proc_read || proc_write) begin
          if (hit) begin
            if (proc_read) proc_rdata = blk_q[hit_way][idx][off];
          end else begin
            proc_stall = 1'b1;
            state_nxt  = (valid[idx][vic_sel] && dirty[idx][vic_sel]) ? WB : ALLOC;
          end
        end
      end
      WB: begin
        proc_stall = 1'b1;
        mem_write  = 1'b1;
        mem_addr   = {tag_q[vic_way][idx], idx};
        if (mem_ready) state_nxt = ALLOC;
      end
      ALLOC: begin
        proc_stall = 1'b1;
        mem_read   = 1'b1;
        if (mem_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge proc_reset) begin
    if (!proc_reset) begin
      state    <= IDLE;
      retry    <= 1'b0;
      vic_way  <= 1'b0;
      lru      <= '0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid[s] <= '0;
        dirty[s] <= '0;
      end
    end else begin
      state <= state_nxt;
      // The replay after a fill hits by construction and must not count as a hit.
      retry <= (state == ALLOC) && mem_ready;
      if (lookup && hit) begin
        lru[idx] <= ~hit_way;
        if (proc_write) dirty[idx][hit_way] <= 1'b1;
        if (!retry && hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
      end
      if (lookup && !hit) begin
        vic_way <= vic_sel;
        if (miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
      end
      if (state == WB && mem_ready) dirty[idx][vic_way] <= 1'b0;
      if (state == ALLOC && mem_ready) begin
        valid[idx][vic_way] <= 1'b1;
        dirty[idx][vic_way] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == ALLOC && mem_ready) begin
      blk_q[vic_way][idx] <= mem_rdata;
      tag_q[vic_way][idx] <= req_tag;
    end
    if (lookup && hit && proc_write) blk_q[hit_way][idx][off] <= proc_wdata;
  end
endmodule

// File: tb/tb_cache_sa_wb.sv
// Directed bench for cache_sa_wb: request-level cache model, latency-2 block memory, per-cycle output checks.
module tb_cache_sa_wb;
  localparam int ADDR_W = 30, DATA_W = 32, NUM_SETS = 4, BLK_WORDS = 4, CNT_W = 8;
  localparam int MLAT = 2;
  localparam int CMAX = (1 << CNT_W) - 1;

  logic clk, proc_reset, proc_read, proc_write, proc_stall;
  logic mem_read, mem_write, mem_ready;
  logic [ADDR_W-1:0] proc_addr;
  logic [31:0] proc_wdata, proc_rdata;
  logic [27:0] mem_addr;
  logic [127:0] mem_wdata, mem_rdata;
  logic [CNT_W-1:0] hit_cnt, miss_cnt;

  cache_sa_wb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_SETS(NUM_SETS),
                .BLK_WORDS(BLK_WORDS), .CNT_W(CNT_W)) dut (
    .clk(clk), .proc_reset(proc_reset), .proc_read(proc_read), .proc_write(proc_write),
    .proc_addr(proc_addr), .proc_wdata(proc_wdata), .proc_rdata(proc_rdata),
    .proc_stall(proc_stall), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0, n_fail = 0;
  logic [31:0] mem  [1024];
  logic [31:0] gold [1024];
  bit  mv [4][2];
  bit  md [4][2];
  int  mt [4][2];
  bit  ml [4];
  int  exp_hit, exp_miss;
  bit  busy;
  bit  obs_w [$];  int obs_a [$];  logic [127:0] obs_d [$];
  bit  ew [$];     int ea [$];     logic [127:0] ed [$];
  bit  last_w [$]; int last_a [$]; logic [127:0] last_d [$];
  logic [31:0] last_rdata;
  int  mcnt;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] gold_blk(input int b);
    logic [127:0] r;
    for (int i = 0; i < 4; i++) r[i*32 +: 32] = gold[b*4+i];
    return r;
  endfunction

  // Block memory: answers after MLAT cycles of a held request with a one-cycle ready pulse.
  initial begin
    mem_ready = 1'b0; mem_rdata = '0; mcnt = 0;
    forever begin
      @(negedge clk);
      if (!proc_reset || mem_ready) begin
        mem_ready = 1'b0; mcnt = 0;
      end else if (mem_read || mem_write) begin
        mcnt++;
        if (mcnt >= MLAT) begin
          int b;
          b = int'(mem_addr[7:0]);
          mem_ready = 1'b1;
          obs_w.push_back(mem_write); obs_a.push_back(int'(mem_addr)); obs_d.push_back(mem_wdata);
          for (int i = 0; i < 4; i++) begin
            if (mem_write) mem[b*4+i] = mem_wdata[i*32 +: 32];
            else mem_rdata[i*32 +: 32] = mem[b*4+i];
          end
        end
      end else mcnt = 0;
    end
  end

  // Per-cycle check of every output against the model.
  initial begin
    forever begin
      @(negedge clk); #2;
      if (proc_reset) begin
        chk("hit_cnt", hit_cnt, exp_hit);
        chk("miss_cnt", miss_cnt, exp_miss);
        chk("mem_excl", mem_read && mem_write, 0);
        if (!busy) begin
          chk("idle_stall", proc_stall, 0);
          chk("idle_rdata", proc_rdata, 0);
          chk("idle_mem", {mem_read, mem_write}, 0);
        end else if (proc_read && !proc_stall) begin
          chk("rdata", proc_rdata, gold[proc_addr[9:0]]);
        end
      end
    end
  end

  task automatic clear_model();
    for (int s = 0; s < 4; s++) begin
      ml[s] = 0;
      for (int w = 0; w < 2; w++) begin mv[s][w] = 0; md[s][w] = 0; mt[s][w] = 0; end
    end
    exp_hit = 0; exp_miss = 0;
    obs_w.delete(); obs_a.delete(); obs_d.delete();
  endtask

  task automatic do_reset(input bit init);
    @(negedge clk);
    proc_reset = 1'b0; proc_read = 1'b0; proc_write = 1'b0; busy = 1'b0;
    clear_model();
    if (init) for (int i = 0; i < 1024; i++) mem[i] = i;
    repeat (2) @(negedge clk);
    proc_reset = 1'b1;
    for (int i = 0; i < 1024; i++) gold[i] = mem[i];
  endtask

  task automatic do_req(input bit wr, input int a, input logic [31:0] wd);
    int s, t, w, v, n;
    bit hit;
    s = (a >> 2) % 4; t = a >> 4; hit = 0; w = 0;
    for (int i = 0; i < 2; i++) if (mv[s][i] && mt[s][i] == t) begin hit = 1; w = i; end
    ew.delete(); ea.delete(); ed.delete();
    if (!hit) begin
      v = !mv[s][0] ? 0 : (!mv[s][1] ? 1 : int'(ml[s]));
      if (mv[s][v] && md[s][v]) begin
        ew.push_back(1); ea.push_back(mt[s][v]*4 + s); ed.push_back(gold_blk(mt[s][v]*4 + s));
      end
      ew.push_back(0); ea.push_back(t*4 + s); ed.push_back('0);
      mv[s][v] = 1; md[s][v] = 0; mt[s][v] = t; w = v;
    end
    if (wr) begin md[s][w] = 1; gold[a] = wd; end
    ml[s] = (w == 0);
    @(negedge clk);
    proc_read = !wr; proc_write = wr; proc_addr = a; proc_wdata = wd; busy = 1'b1;
    #1;
    chk("stall_first", proc_stall, !hit);
    last_rdata = proc_rdata;
    @(posedge clk);
    if (hit) begin if (exp_hit < CMAX) exp_hit++; end
    else if (exp_miss < CMAX) exp_miss++;
    if (!hit) begin
      n = 0;
      do begin @(negedge clk); #1; n++; end while (proc_stall && n < 200);
      chk("miss_done", proc_stall, 0);
      last_rdata = proc_rdata;
      @(posedge clk);
    end
    #1;
    proc_read = 1'b0; proc_write = 1'b0; busy = 1'b0;
    chk("mem_n", obs_w.size(), ew.size());
    for (int i = 0; i < ew.size() && i < obs_w.size(); i++) begin
      chk("mem_kind", obs_w[i], ew[i]);
      chk("mem_addr", obs_a[i], ea[i]);
      if (ew[i]) chk("mem_wdata", obs_d[i], ed[i]);
    end
    last_w = obs_w; last_a = obs_a; last_d = obs_d;
    obs_w.delete(); obs_a.delete(); obs_d.delete();
  endtask

  initial begin
    int n;
    proc_reset = 1'b0; proc_read = 1'b0; proc_write = 1'b0; proc_addr = '0; proc_wdata = '0;
    busy = 1'b0; clear_model();
    do_reset(1);
    #1;
    chk("rst_hit", hit_cnt, 0); chk("rst_miss", miss_cnt, 0);
    chk("rst_mem", {mem_read, mem_write}, 0); chk("rst_stall", proc_stall, 0);

    // Sequential reads: one fetch per block, block addresses 0..7.
    for (int a = 0; a < 32; a++) begin
      do_req(0, a, 0);
      chk("t1_data", last_rdata, a);
      chk("t1_nfetch", last_w.size(), (a % 4 == 0) ? 1 : 0);
      if (last_w.size() > 0) chk("t1_faddr", last_a[0], a / 4);
    end
    @(negedge clk); #1;
    chk("t1_miss8", miss_cnt, 8); chk("t1_hit24", hit_cnt, 24);

    // Clean eviction in set 0.
    do_reset(1);
    do_req(0, 0, 0); do_req(0, 16, 0); do_req(0, 32, 0);
    chk("t2_n", last_w.size(), 1);
    if (last_w.size() == 1) begin chk("t2_kind", last_w[0], 0); chk("t2_addr", last_a[0], 8); end
    do_req(0, 16, 0);
    chk("t2_rehit", last_w.size(), 0);

    // Dirty eviction writes back before fetching.
    do_reset(1);
    do_req(0, 0, 0); do_req(1, 0, 32'hAA); do_req(0, 16, 0); do_req(0, 32, 0);
    chk("t3_n", last_w.size(), 2);
    if (last_w.size() == 2) begin
      chk("t3_wb", last_w[0], 1); chk("t3_wb_addr", last_a[0], 0);
      chk("t3_wb_w0", last_d[0][31:0], 32'hAA);
      chk("t3_rd", last_w[1], 0); chk("t3_rd_addr", last_a[1], 8);
    end
    do_req(0, 0, 0);
    chk("t3_readback", last_rdata, 32'hAA);

    // Full-range write then interleaved conflicting reads.
    do_reset(1);
    for (int k = 0; k < 1024; k++) do_req(1, k, 3*k + 1);
    for (int g = 0; g < 16; g++)
      for (int j = 0; j < 32; j++) begin
        do_req(0, g*64 + j, 0);
        chk("t4_a", last_rdata, 3*(g*64 + j) + 1);
        do_req(0, g*64 + 32 + j, 0);
        chk("t4_b", last_rdata, 3*(g*64 + 32 + j) + 1);
      end

    // Reset during a write-back.
    do_reset(1);
    do_req(1, 0, 32'h55); do_req(0, 16, 0);
    @(negedge clk);
    proc_read = 1'b1; proc_addr = 32; busy = 1'b1;
    n = 0;
    do begin @(negedge clk); #1; n++; end while (!mem_write && n < 50);
    chk("t5_wb_seen", mem_write, 1);
    proc_read = 1'b0; busy = 1'b0; proc_reset = 1'b0;
    #1;
    chk("t5_wr_drop", mem_write, 0); chk("t5_hit0", hit_cnt, 0); chk("t5_miss0", miss_cnt, 0);
    clear_model();
    repeat (2) @(negedge clk);
    proc_reset = 1'b1;
    for (int i = 0; i < 1024; i++) gold[i] = mem[i];
    do_req(0, 0, 0);
    chk("t5_n", last_w.size(), 1);
    if (last_w.size() == 1) chk("t5_nowb", last_w[0], 0);
    chk("t5_lost", last_rdata, 0);

    // Hit counter saturation.
    do_reset(1);
    do_req(0, 0, 0);
    for (int i = 0; i < CMAX - 1; i++) do_req(0, 0, 0);
    @(negedge clk); #1;
    chk("t6_pre", hit_cnt, CMAX - 1);
    do_req(0, 0, 0); do_req(0, 1, 0);
    @(negedge clk); #1;
    chk("t6_sat", hit_cnt, CMAX);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
